// File: rtl/key_pkg.sv
// Shared key-input definitions: FSM states, key polarity and 50 MHz timing defaults.
package key_pkg;

    localparam int unsigned DEF_CNT_MAX  = 999_999;
    localparam int unsigned DEF_LONG_MAX = 49_999_999;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        REL_FILT
    } key_state_e;

endpackage

// File: rtl/key_filter_if.sv
// Key filter bus: raw pad key in, debounced level and event pulses out.
interface key_filter_if;

    logic key_in;
    logic key_out;
    logic key_flag;
    logic key_long;

    modport master (output key_in, input key_out, key_flag, key_long);
    modport slave  (input key_in, output key_out, key_flag, key_long);

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous key pad, with a selectable reset level.
module key_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clock,
    input  logic sys_rst_n,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta   <= RST_VAL;
            synced <= RST_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: synchronised, filtered active-low level plus press pulse.
// Define KEY_LONG_PRESS_EN to add the one-shot long-press pulse on key_long.
module key_filter
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = DEF_CNT_MAX,
    parameter int unsigned LONG_MAX = DEF_LONG_MAX
) (
    input  logic          sys_clock,
    input  logic          sys_rst_n,
    key_filter_if.slave   key_bus
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    logic             key_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_out_q, key_out_d;
    logic             key_flag_q, key_flag_d;
    logic             cnt_at_max;

    key_sync #(.RST_VAL(KEY_RELEASED)) u_key_sync (
        .sys_clock (sys_clock),
        .sys_rst_n (sys_rst_n),
        .raw       (key_bus.key_in),
        .synced    (key_s)
    );

    assign cnt_at_max = (cnt_q == CNT_W'(CNT_MAX));

    // Filter FSM: a level must be seen unbroken for CNT_MAX+1 clocks to be accepted
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_out_d  = key_out_q;
        key_flag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s == KEY_PRESSED) state_d = PRESS_FILT;
            end
            PRESS_FILT: begin
                if (key_s == KEY_RELEASED) begin
                    state_d = IDLE;
                end else if (cnt_at_max) begin
                    state_d    = DOWN;
                    key_out_d  = KEY_PRESSED;
                    key_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s == KEY_RELEASED) state_d = REL_FILT;
            end
            REL_FILT: begin
                if (key_s == KEY_PRESSED) begin
                    state_d = DOWN;
                end else if (cnt_at_max) begin
                    state_d   = IDLE;
                    key_out_d = KEY_RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // every transition restarts the filter window
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_out_q  <= KEY_RELEASED;
            key_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_out_q  <= key_out_d;
            key_flag_q <= key_flag_d;
        end
    end

    assign key_bus.key_out  = key_out_q;
    assign key_bus.key_flag = key_flag_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_MAX + 1);

    logic [LONG_W-1:0] lcnt_q, lcnt_d;
    logic              ldone_q, ldone_d;
    logic              key_long_q, key_long_d;
    logic              long_hit;

    // Counter saturates at LONG_MAX; ldone keeps the pulse to one per press
    assign long_hit = (lcnt_q == LONG_W'(LONG_MAX)) && !ldone_q;

    always_comb begin
        lcnt_d     = lcnt_q;
        ldone_d    = ldone_q | long_hit;
        key_long_d = long_hit;
        if (state_q == DOWN && lcnt_q != LONG_W'(LONG_MAX)) lcnt_d = lcnt_q + LONG_W'(1);
        if (state_d == IDLE && state_q != IDLE) begin
            lcnt_d  = '0;
            ldone_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcnt_q     <= '0;
            ldone_q    <= 1'b0;
            key_long_q <= 1'b0;
        end else begin
            lcnt_q     <= lcnt_d;
            ldone_q    <= ldone_d;
            key_long_q <= key_long_d;
        end
    end

    assign key_bus.key_long = key_long_q;
`else
    logic unused_long_max;
    assign unused_long_max  = (LONG_MAX == 0);
    assign key_bus.key_long = 1'b0;
`endif

endmodule
